// File: rtl/cache_arbiter_pkg.sv
// Shared types for the sa_cache CPU-side port and the two-requester arbiter.
package cache_definition;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;

  // Request presented to the cache.
  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cpu_to_cache_type;

  // Status and read data coming back from the cache.
  typedef struct packed {
    logic              stopped;
    logic              ready;
    logic [DATA_W-1:0] data;
  } cache_to_cpu_type;

  // Arbiter states: ARB picks a winner, HOLD locks onto a stalled request.
  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_owner_fifo.sv
// 1-bit-wide owner FIFO: remembers which requester issued each outstanding read.
module arb_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count tracks occupancy through simultaneous push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port arbiter in front of the sa_cache CPU port (port 0 = fetch, port 1 = data).
// Optional macro ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module cache_arbiter
  import cache_definition::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_rw,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]                rsp_data,
  output cpu_to_cache_type                 cache_req,
  input  cache_to_cpu_type                 cache_rsp,
  output logic                             err_underflow
);

  localparam int CW = $clog2(OUTST_DEPTH) + 1;

  arb_state_t           state;
  arb_state_t           next_state;
  logic                 owner;
  logic                 tie_pref;
  logic [NUM_REQ-1:0]   candidate;
  logic                 winner;
  logic                 present;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_pref = 1'b0;
`else
  logic rr_ptr;

  // Round-robin pointer: the port that did not just win gets the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~winner;
  end

  assign tie_pref = rr_ptr;
`endif

  // State register for the ARB/HOLD lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= next_state;
  end

  // Remember which port stalled so HOLD keeps presenting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               owner <= 1'b0;
    else if (state == ARB && present && cache_rsp.stopped) owner <= winner;
  end

  // Winner selection, cache request drive, grant and next state.
  always_comb begin
    candidate  = '0;
    winner     = 1'b0;
    present    = 1'b0;
    accept     = 1'b0;
    cache_req  = '0;
    req_grant  = '0;
    next_state = state;
    if (state == HOLD) begin
      winner  = owner;
      present = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        candidate[i] = req_valid[i] & (req_rw[i] | ~fifo_full);
      present = |candidate;
      if (&candidate) winner = tie_pref;
      else            winner = candidate[1];
    end
    if (rst) present = 1'b0;
    accept = present & ~cache_rsp.stopped;
    if (present) begin
      cache_req.valid = 1'b1;
      cache_req.rw    = req_rw[winner];
      cache_req.addr  = req_addr[winner];
      cache_req.data  = req_data[winner];
    end
    if (accept) req_grant[winner] = 1'b1;
    case (state)
      ARB:     if (present && cache_rsp.stopped) next_state = HOLD;
      HOLD:    if (!cache_rsp.stopped)           next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  assign push = accept & ~cache_req.rw;
  assign pop  = cache_rsp.ready & ~fifo_empty;

  // Route each in-order read response to the port at the FIFO head.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pop) begin
      rsp_valid[fifo_head] = 1'b1;
      rsp_data             = cache_rsp.data;
    end
  end

  // Sticky error: the cache returned data nobody is waiting for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           err_underflow <= 1'b0;
    else if (cache_rsp.ready && fifo_count == CW'(0))  err_underflow <= 1'b1;
  end

  arb_owner_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (winner),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single sa_cache CPU-side port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Selects one request per cycle and drives it onto the cache's cpu_to_cache input.
- Holds the selection while the cache reports stopped.
- Routes in-order read responses back to the issuing requester, using an owner-tag FIFO.

Parameters:
- OUTST_DEPTH, 4, depth of the outstanding-read owner FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  2  per-requester request valid; bit i belongs to port i.
- req_rw  in  2  per-requester access type: 1 = write, 0 = read.
- req_addr  in  2x20  per-requester word address.
- req_data  in  2x32  per-requester write data.
- req_grant  out  2  request accepted by the cache this cycle (one-hot or zero).
- rsp_valid  out  2  read data valid for port i.
- rsp_data  out  32  read data, shared by both ports.
- cache_req  out  cpu_to_cache_type  request to the cache (valid, rw, addr, data).
- cache_rsp  in  cache_to_cpu_type  cache status (stopped, ready, data).
- err_underflow  out  1  sticky flag: cache_rsp.ready seen while the owner FIFO is empty.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - state to ARB
  - rr_ptr to 0
  - FIFO pointers and count to 0
  - err_underflow to 0
- Outputs under reset: req_grant=0, rsp_valid=0, rsp_data=0, cache_req.valid=0.
- FSM has two states, ARB and HOLD, plus a registered owner bit.
- ARB state:
  - Candidate set = ports with req_valid=1, excluding any read-port when the FIFO is full (count==OUTST_DEPTH).
  - Pick the candidate using round-robin: port rr_ptr wins a tie.
  - Drive cache_req combinationally from the winner: valid=1, rw, addr, data.
  - No candidate: cache_req.valid=0 and addr/data=0.
- Acceptance occurs at a posedge where cache_req.valid=1 and cache_rsp.stopped=0. On acceptance:
  - req_grant[winner]=1 in that cycle (combinational).
  - rr_ptr <= ~winner.
  - If the access is a read, push winner into the FIFO.
- Stall: if cache_rsp.stopped=1 while cache_req.valid=1, then owner <= winner and the FSM goes to HOLD.
- HOLD state:
  - cache_req is driven from the port held in owner, regardless of the other port.
  - req_grant=0 while stopped=1.
  - The first cycle with stopped=0 accepts the held request (grant, FIFO push if read, rr_ptr update) and returns to ARB.
- Requester contract: req_valid, rw, addr and data stay stable from assertion until req_grant. If req_valid drops in HOLD, the arbiter still presents the held request. The bench treats that as a protocol violation.
- Responses:
  - On cache_rsp.ready=1, pop the FIFO head h. Assert rsp_valid[h]=1 and rsp_data=cache_rsp.data in the same cycle (combinational).
  - Push and pop in the same cycle is legal and leaves count unchanged. A push when full cannot occur, because reads are masked when full.
  - ready with count==0: set err_underflow, no rsp_valid, no pop.
- Writes never push; they get no response.
- FIFO pointers are log2(OUTST_DEPTH) bits and wrap modulo OUTST_DEPTH. count is log2(OUTST_DEPTH)+1 bits.
- Reset asserted mid-HOLD or with reads outstanding drops everything. Late cache ready pulses after reset set err_underflow.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a tie; rr_ptr is not implemented.
- Undefined: round-robin as above.
- Both builds keep the HOLD lock and FIFO-full masking unchanged.

Decomposition:
- cache_definition package:
  - Existing cpu_to_cache_type and cache_to_cpu_type.
  - New arb_state_t enum {ARB, HOLD}.
  - New NUM_REQ=2 constant.
- Sub-module arb_owner_fifo: 1-bit-wide synchronous FIFO with push, pop, full, empty, head, count outputs, parameter DEPTH. Instantiated once.

Test Plan:
- Only port 1 read addr 20'h00010, cache stopped=0 -> req_grant=2'b10 in the same cycle. A later ready with data 32'hDEADBEEF -> rsp_valid=2'b10, rsp_data=32'hDEADBEEF.
- Both ports read every cycle, no stalls, rr_ptr=0 after reset -> grants alternate 01,10,01,10. Responses return in the same owner order.
- Port 0 read misses (stopped high 8 cycles) while port 1 requests -> cache_req holds port 0 address for all 8 cycles. Port 0 is granted when stopped falls; port 1 is granted the next cycle.
- Cache ready never pulses, port 0 issues 5 reads with OUTST_DEPTH=4 -> 4 grants, then no further read grant. A port 1 write is still granted.
- rst pulsed while in HOLD with 3 reads outstanding -> all outputs 0 at once. The next ready pulse sets err_underflow=1 with no rsp_valid.
- ARB_FIXED_PRIO_EN defined, both ports request continuously, no stalls -> port 0 granted every cycle and port 1 never granted.
